// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control_sequencer state, opcode and strobe encodings
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_MULW  = 3'd3,
    S_HALT  = 3'd4,
    S_IRQ   = 3'd5
  } state_t;

  localparam logic [1:0] CLS_SINGLE = 2'b00;
  localparam logic [1:0] CLS_DOUBLE = 2'b01;
  localparam logic [1:0] CLS_TRIPLE = 2'b10;
  localparam logic [1:0] CLS_DIRECT = 2'b11;

  localparam logic [2:0] MUL_TOP3 = 3'b100;
  localparam logic [2:0] MLS_TOP3 = 3'b101;
  localparam logic [3:0] STP_TOP4 = 4'hF;

  // Sub-opcode nibble following the class bits
  localparam logic [3:0] SUB_LSR = 4'd1, SUB_ASR = 4'd2, SUB_CLEAR = 4'd3,
                         SUB_PUSH = 4'd4, SUB_POP = 4'd5, SUB_LDI = 4'd6;
  localparam logic [3:0] SUB_ADD = 4'd0, SUB_SUB = 4'd1, SUB_AND = 4'd2, SUB_OR = 4'd3,
                         SUB_XOR = 4'd4, SUB_MOV = 4'd5, SUB_STORE = 4'd6,
                         SUB_LOAD = 4'd7, SUB_AIM = 4'd8, SUB_SIM = 4'd9;
  localparam logic [3:0] SUB_JMR = 4'd0, SUB_JMD = 4'd1, SUB_CALL = 4'd2, SUB_RTN = 4'd3;

  localparam logic [1:0] JS_REL = 2'b00;
  localparam logic [1:0] JS_DIR = 2'b01;
  localparam logic [1:0] JS_RTN = 2'b10;
  localparam logic [1:0] JS_VEC = 2'b11;

  typedef enum logic [5:0] {
    E_NOP = 6'd0,  E_LSR = 6'd1,  E_ASR = 6'd2,  E_CLEAR = 6'd3, E_PUSH = 6'd4,
    E_POP = 6'd5,  E_LDI = 6'd6,  E_ADD = 6'd7,  E_SUB = 6'd8,   E_AND = 6'd9,
    E_OR  = 6'd10, E_XOR = 6'd11, E_MOV = 6'd12, E_STORE = 6'd13, E_LOAD = 6'd14,
    E_AIM = 6'd15, E_SIM = 6'd16, E_MUL = 6'd17, E_MLS = 6'd18,  E_JMR = 6'd19,
    E_JMD = 6'd20, E_CALL = 6'd21, E_RTN = 6'd22, E_STP = 6'd23
  } eop_t;

  typedef struct packed {
    logic jmr, jmd, call, rtn, push, store, lsr, asr, alu, clear;
    logic ldi, aim, sim, load, pop, mul, stp;
  } dec_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// rtl/ctrl_opcode_decode.sv - IR top bits to one-hot mnemonic flags and compact opcode
module ctrl_opcode_decode
  import ctrl_pkg::*;
(
  input  logic [11:0] ir_top,
  output dec_t        dec,
  output logic [5:0]  encoded_opcode
);

  eop_t op;

  always_comb begin
    op = E_NOP;
    if (ir_top[11:8] == STP_TOP4 && ir_top[7:1] == 7'd0 && ir_top[0]) op = E_STP;
    else if (ir_top[11:9] == MUL_TOP3) op = E_MUL;
    else if (ir_top[11:9] == MLS_TOP3) op = E_MLS;
    else begin
      case (ir_top[11:6])
        {CLS_SINGLE, SUB_LSR}:   op = E_LSR;
        {CLS_SINGLE, SUB_ASR}:   op = E_ASR;
        {CLS_SINGLE, SUB_CLEAR}: op = E_CLEAR;
        {CLS_SINGLE, SUB_PUSH}:  op = E_PUSH;
        {CLS_SINGLE, SUB_POP}:   op = E_POP;
        {CLS_SINGLE, SUB_LDI}:   op = E_LDI;
        {CLS_DOUBLE, SUB_ADD}:   op = E_ADD;
        {CLS_DOUBLE, SUB_SUB}:   op = E_SUB;
        {CLS_DOUBLE, SUB_AND}:   op = E_AND;
        {CLS_DOUBLE, SUB_OR}:    op = E_OR;
        {CLS_DOUBLE, SUB_XOR}:   op = E_XOR;
        {CLS_DOUBLE, SUB_MOV}:   op = E_MOV;
        {CLS_DOUBLE, SUB_STORE}: op = E_STORE;
        {CLS_DOUBLE, SUB_LOAD}:  op = E_LOAD;
        {CLS_DOUBLE, SUB_AIM}:   op = E_AIM;
        {CLS_DOUBLE, SUB_SIM}:   op = E_SIM;
        {CLS_DIRECT, SUB_JMR}:   op = E_JMR;
        {CLS_DIRECT, SUB_JMD}:   op = E_JMD;
        {CLS_DIRECT, SUB_CALL}:  op = E_CALL;
        {CLS_DIRECT, SUB_RTN}:   op = E_RTN;
        default:                 op = E_NOP;
      endcase
    end
  end

  always_comb begin
    dec = '0;
    case (op)
      E_LSR:   dec.lsr   = 1'b1;
      E_ASR:   dec.asr   = 1'b1;
      E_CLEAR: dec.clear = 1'b1;
      E_PUSH:  dec.push  = 1'b1;
      E_POP:   dec.pop   = 1'b1;
      E_LDI:   dec.ldi   = 1'b1;
      E_ADD, E_SUB, E_AND, E_OR, E_XOR, E_MOV: dec.alu = 1'b1;
      E_STORE: dec.store = 1'b1;
      E_LOAD:  dec.load  = 1'b1;
      E_AIM:   dec.aim   = 1'b1;
      E_SIM:   dec.sim   = 1'b1;
      E_MUL, E_MLS: dec.mul = 1'b1;
      E_JMR:   dec.jmr   = 1'b1;
      E_JMD:   dec.jmd   = 1'b1;
      E_CALL:  dec.call  = 1'b1;
      E_RTN:   dec.rtn   = 1'b1;
      E_STP:   dec.stp   = 1'b1;
      default: dec = '0;
    endcase
  end

  assign encoded_opcode = op;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute sequencer owning the IR; CTRL_IRQ_EN adds the interrupt state
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSTR_W-1:0]    instr_in,
  input  logic                  mem_ready,
  input  logic                  stack_overflow,
  input  logic                  resume,
  output logic [2:0]            state,
  output logic [5:0]            encoded_opcode,
  output logic                  ir_en,
  output logic                  ext_en,
  output logic                  pc_cnt_en,
  output logic                  pc_sload,
  output logic [1:0]            jump_sel,
  output logic                  ram_wren_data,
  output logic [REG_ADDR_W-1:0] reg_write_address,
  output logic [REG_ADDR_W-1:0] reg_read_address,
  output logic                  reg_we,
  output logic                  reg_shift_en,
  output logic                  reg_clear,
  output logic                  mul_busy,
  output logic                  stop
`ifdef CTRL_IRQ_EN
  ,
  input  logic                  irq,
  input  logic                  irq_ie,
  output logic                  irq_ack
`endif
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_t             st, st_nx;
  logic [INSTR_W-1:0] ir;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               go_fetch;
  dec_t               dec;
  logic [5:0]         eop;

  ctrl_opcode_decode u_dec (
    .ir_top         (ir[INSTR_W-1 -: 12]),
    .dec            (dec),
    .encoded_opcode (eop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= S_FETCH;
      ir  <= '0;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      if (ir_en) ir <= instr_in;
    end
  end

  // The counter doubles as the HALT entry marker so reg_clear fires only once
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    go_fetch = 1'b0;
    case (st)
      S_FETCH: if (mem_ready) st_nx = S_EXEC1;
      S_EXEC1: begin
        if (dec.ldi || dec.aim || dec.sim || dec.load || dec.pop) st_nx = S_EXEC2;
        else if (dec.mul && MUL_CYCLES > 1) begin
          st_nx  = S_MULW;
          cnt_nx = CW'(MUL_CYCLES - 2);
        end else if (dec.stp) st_nx = S_HALT;
        else go_fetch = 1'b1;
      end
      S_EXEC2: if (mem_ready) go_fetch = 1'b1;
      S_MULW: begin
        if (cnt == '0) go_fetch = 1'b1;
        else cnt_nx = cnt - 1'b1;
      end
      S_HALT: begin
        cnt_nx = '0;
        if (resume && !stack_overflow) go_fetch = 1'b1;
      end
      default: st_nx = S_FETCH;
    endcase
    if (go_fetch) st_nx = S_FETCH;
`ifdef CTRL_IRQ_EN
    if (go_fetch && irq && irq_ie) st_nx = S_IRQ;
`endif
    if (stack_overflow && st != S_HALT) st_nx = S_HALT;
    if (st_nx == S_HALT && st != S_HALT) cnt_nx = CW'(1);
  end

  always_comb begin
    ir_en         = 1'b0;
    ext_en        = 1'b0;
    pc_cnt_en     = 1'b0;
    pc_sload      = 1'b0;
    jump_sel      = JS_REL;
    ram_wren_data = 1'b0;
    reg_we        = 1'b0;
    reg_shift_en  = 1'b0;
    reg_clear     = 1'b0;
    mul_busy      = 1'b0;
    stop          = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack       = 1'b0;
`endif
    case (st)
      S_FETCH: begin
        ir_en     = mem_ready;
        pc_cnt_en = mem_ready;
      end
      S_EXEC1: begin
        pc_sload      = dec.jmr | dec.jmd | dec.call | dec.rtn;
        if (dec.jmd || dec.call) jump_sel = JS_DIR;
        if (dec.rtn) jump_sel = JS_RTN;
        ram_wren_data = dec.call | dec.push | dec.store;
        reg_shift_en  = dec.lsr | dec.asr;
        reg_we        = dec.alu | (dec.mul && MUL_CYCLES == 1);
        reg_clear     = dec.clear;
      end
      S_EXEC2: begin
        ext_en    = mem_ready;
        pc_cnt_en = mem_ready;
        reg_we    = mem_ready & ~dec.sim;
      end
      S_MULW: begin
        mul_busy = 1'b1;
        reg_we   = (cnt == '0);
      end
      S_HALT: begin
        stop      = 1'b1;
        reg_clear = (cnt != '0);
      end
`ifdef CTRL_IRQ_EN
      S_IRQ: begin
        ram_wren_data = 1'b1;
        pc_sload      = 1'b1;
        jump_sel      = JS_VEC;
        irq_ack       = 1'b1;
      end
`endif
      default: ;
    endcase
    if (stack_overflow && st != S_HALT) begin
      pc_sload      = 1'b0;
      ram_wren_data = 1'b0;
      reg_we        = 1'b0;
    end
  end

  assign state             = st;
  assign encoded_opcode    = (st == S_EXEC1 || st == S_EXEC2 || st == S_MULW) ? eop : 6'd0;
  assign reg_write_address = ir[REG_ADDR_W-1:0];
  assign reg_read_address  = ir[2*REG_ADDR_W-1:REG_ADDR_W];

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and randomized checks of control_sequencer against a reference model
module tb_control_sequencer;

  localparam int MUL_CYCLES = 4;

  logic        clk, rst_n;
  logic [15:0] instr_in;
  logic        mem_ready, stack_overflow, resume;
  logic [2:0]  state;
  logic [5:0]  encoded_opcode;
  logic        ir_en, ext_en, pc_cnt_en, pc_sload, ram_wren_data;
  logic [1:0]  jump_sel;
  logic [2:0]  reg_write_address, reg_read_address;
  logic        reg_we, reg_shift_en, reg_clear, mul_busy, stop;
`ifdef CTRL_IRQ_EN
  logic        irq, irq_ie, irq_ack;
`endif

  control_sequencer #(.INSTR_W(16), .REG_ADDR_W(3), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .mem_ready(mem_ready),
    .stack_overflow(stack_overflow), .resume(resume), .state(state),
    .encoded_opcode(encoded_opcode), .ir_en(ir_en), .ext_en(ext_en),
    .pc_cnt_en(pc_cnt_en), .pc_sload(pc_sload), .jump_sel(jump_sel),
    .ram_wren_data(ram_wren_data), .reg_write_address(reg_write_address),
    .reg_read_address(reg_read_address), .reg_we(reg_we),
    .reg_shift_en(reg_shift_en), .reg_clear(reg_clear), .mul_busy(mul_busy),
    .stop(stop)
`ifdef CTRL_IRQ_EN
    , .irq(irq), .irq_ie(irq_ie), .irq_ack(irq_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 fetch, 1 decode, 2 extension word, 3 multiply wait, 4 halted, 5 irq
  int          mst;
  int          mleft;
  bit          mnew;
  logic [15:0] mir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mnemonic numbering from the instruction word: 0 unknown, 1..23 as in the opcode list
  function automatic int code_of(input logic [15:0] w);
    if (w[15:12] == 4'hF && w[11:5] == 7'd0 && w[4]) return 23;
    if (w[15:13] == 3'b100) return 17;
    if (w[15:13] == 3'b101) return 18;
    case (w[15:10])
      6'b000001: return 1;   6'b000010: return 2;   6'b000011: return 3;
      6'b000100: return 4;   6'b000101: return 5;   6'b000110: return 6;
      6'b010000: return 7;   6'b010001: return 8;   6'b010010: return 9;
      6'b010011: return 10;  6'b010100: return 11;  6'b010101: return 12;
      6'b010110: return 13;  6'b010111: return 14;  6'b011000: return 15;
      6'b011001: return 16;  6'b110000: return 19;  6'b110001: return 20;
      6'b110010: return 21;  6'b110011: return 22;
      default:   return 0;
    endcase
  endfunction

  function automatic bit is_ext(input int c);
    return c == 5 || c == 6 || c == 14 || c == 15 || c == 16;
  endfunction

  task automatic model_reset();
    mst = 0; mleft = 0; mnew = 0; mir = '0;
  endtask

  task automatic compare_outputs();
    int c;
    logic e_ir, e_ext, e_pcc, e_sl, e_wr, e_we, e_sh, e_clr, e_busy, e_stop, e_ack;
    logic [1:0] e_js;
    c = code_of(mir);
    {e_ir, e_ext, e_pcc, e_sl, e_wr, e_we, e_sh, e_clr, e_busy, e_stop, e_ack} = '0;
    e_js = 2'b00;
    case (mst)
      0: begin e_ir = mem_ready; e_pcc = mem_ready; end
      1: begin
        if (c == 19) e_sl = 1;
        if (c == 20) begin e_sl = 1; e_js = 2'b01; end
        if (c == 21) begin e_sl = 1; e_js = 2'b01; e_wr = 1; end
        if (c == 22) begin e_sl = 1; e_js = 2'b10; end
        if (c == 4 || c == 13) e_wr = 1;
        if (c == 1 || c == 2) e_sh = 1;
        if (c >= 7 && c <= 12) e_we = 1;
        if (c == 3) e_clr = 1;
        if ((c == 17 || c == 18) && MUL_CYCLES == 1) e_we = 1;
      end
      2: if (mem_ready) begin e_ext = 1; e_pcc = 1; e_we = (c != 16); end
      3: begin e_busy = 1; e_we = (mleft == 1); end
      4: begin e_stop = 1; e_clr = mnew; end
      5: begin e_wr = 1; e_sl = 1; e_js = 2'b11; e_ack = 1; end
      default: ;
    endcase
    if (stack_overflow && mst != 4) begin e_sl = 0; e_wr = 0; e_we = 0; end
    check_eq("state", {29'd0, state}, mst);
    check_eq("encoded_opcode", {26'd0, encoded_opcode}, (mst >= 1 && mst <= 3) ? c : 0);
    check_eq("strobes",
             {20'd0, ir_en, ext_en, pc_cnt_en, pc_sload, jump_sel, ram_wren_data,
              reg_we, reg_shift_en, reg_clear, mul_busy, stop},
             {20'd0, e_ir, e_ext, e_pcc, e_sl, e_js, e_wr, e_we, e_sh, e_clr, e_busy, e_stop});
    check_eq("reg_addr", {26'd0, reg_write_address, reg_read_address}, {26'd0, mir[2:0], mir[5:3]});
`ifdef CTRL_IRQ_EN
    check_eq("irq_ack", {31'd0, irq_ack}, {31'd0, e_ack});
`else
    if (e_ack) check_eq("irq_state_reached", 32'd1, 32'd0);
`endif
  endtask

  task automatic model_step();
    int c, nx;
    c  = code_of(mir);
    nx = mst;
    case (mst)
      0: if (mem_ready) begin mir = instr_in; nx = 1; end
      1: begin
        if (is_ext(c)) nx = 2;
        else if ((c == 17 || c == 18) && MUL_CYCLES > 1) begin nx = 3; mleft = MUL_CYCLES - 1; end
        else if (c == 23) begin nx = 4; mnew = 1; end
        else nx = 0;
      end
      2: if (mem_ready) nx = 0;
      3: if (mleft == 1) nx = 0; else mleft--;
      4: begin mnew = 0; if (resume && !stack_overflow) nx = 0; end
      default: nx = 0;
    endcase
`ifdef CTRL_IRQ_EN
    if (nx == 0 && mst != 0 && mst != 5 && irq && irq_ie) nx = 5;
`endif
    if (stack_overflow && mst != 4) begin nx = 4; mnew = 1; end
    mst = nx;
  endtask

  task automatic tick(input logic [15:0] w, input logic mr, input logic ovf, input logic res);
    instr_in = w; mem_ready = mr; stack_overflow = ovf; resume = res;
    #1;
    compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [5:0] ops [20];
    int k;
    ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h10, 6'h11, 6'h12, 6'h13,
            6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19, 6'h20, 6'h28, 6'h30, 6'h32};
    k = $urandom_range(0, 27);
    if (k < 20) return {ops[k], 10'($urandom)};
    if (k < 22) return 16'hF010 | 16'($urandom_range(0, 15));
    if (k == 22) return {6'h31, 10'($urandom)};
    if (k == 23) return {6'h33, 10'($urandom)};
    return 16'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; instr_in = '0; mem_ready = 1'b0; stack_overflow = 1'b0; resume = 1'b0;
`ifdef CTRL_IRQ_EN
    irq = 1'b0; irq_ie = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;

    // ADD r1,r2
    tick(16'h4011, 1, 0, 0);
    check_eq("add_exec1_we", {31'd0, reg_we}, 32'd0 | 32'(state == 3'd1));
    check_eq("add_state", {29'd0, state}, 32'd1);
    tick(16'h0000, 1, 0, 0);
    check_eq("add_back_fetch", {29'd0, state}, 32'd0);

    // LDI with a 3-cycle stall in EXEC2
    tick(16'h1805, 1, 0, 0);
    tick(16'h0000, 1, 0, 0);
    repeat (3) tick(16'h0000, 0, 0, 0);
    tick(16'h0000, 1, 0, 0);
    check_eq("ldi_total", {29'd0, state}, 32'd0);

    // MUL: back to FETCH after 1 + MUL_CYCLES cycles
    tick(16'h801A, 1, 0, 0);
    repeat (MUL_CYCLES) tick(16'h0000, 1, 0, 0);
    check_eq("mul_back_fetch", {29'd0, state}, 32'd0);

    // STP, hold 5 cycles, resume
    tick(16'hF010, 1, 0, 0);
    tick(16'h0000, 1, 0, 0);
    check_eq("halt_stop", {31'd0, stop}, 32'd1);
    repeat (5) tick(16'h0000, 1, 0, 0);
    tick(16'h0000, 1, 0, 1);
    check_eq("resume_stop", {31'd0, stop}, 32'd0);

    // stack_overflow during CALL decode
    tick(16'hC800, 1, 0, 0);
    tick(16'h0000, 1, 1, 0);
    check_eq("ovf_halt", {29'd0, state}, 32'd4);
    tick(16'h0000, 1, 1, 1);
    check_eq("ovf_resume_blocked", {29'd0, state}, 32'd4);
    tick(16'h0000, 1, 0, 1);

    // Reset in the middle of a multiply wait
    tick(16'hA03F, 1, 0, 0);
    tick(16'h0000, 1, 0, 0);
    tick(16'h0000, 1, 0, 0);
    rst_n = 1'b0; mem_ready = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef CTRL_IRQ_EN
    irq = 1'b1; irq_ie = 1'b1;
    tick(16'h4011, 1, 0, 0);
    tick(16'h0000, 1, 0, 0);
    check_eq("irq_enter", {29'd0, state}, 32'd5);
    tick(16'h0000, 0, 0, 0);
    irq_ie = 1'b0;
    tick(16'h4011, 1, 0, 0);
    tick(16'h0000, 1, 0, 0);
    check_eq("irq_masked", {29'd0, state}, 32'd0);
    irq = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
`ifdef CTRL_IRQ_EN
      irq    = ($urandom_range(0, 7) == 0);
      irq_ie = 1'($urandom_range(0, 1));
`endif
      tick(rand_word(), $urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
